// File: rtl/output_byte_fifo_if.sv
// Handshake bundle between the cipher core / host pins and the output byte FIFO.
// master = producer and host side, slave = the FIFO itself.
interface output_byte_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              output_acknowledge;
    logic [DATA_W-1:0] data_out;
    logic              output_byte_is_ready;

    modport master (
        output wr_valid,
        output wr_data,
        output output_acknowledge,
        input  wr_ready,
        input  data_out,
        input  output_byte_is_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  output_acknowledge,
        output wr_ready,
        output data_out,
        output output_byte_is_ready
    );
endinterface

// File: rtl/output_byte_fifo.sv
// Output word buffer between the cipher core and the host pins; each host ack rising edge pops the head.
// Optional macro OUTPUT_FIFO_ACK_SYNC_EN adds a 2-flop synchronizer on output_acknowledge.
module output_byte_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     interface_busy,
    output logic                     input_acknowledged,
    output logic [CNT_W-1:0]         fill_level,
    output logic                     overflow,
    output_byte_fifo_if.slave        bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              overflow_q, overflow_d;
    logic              ack_prev_q, ack_prev_d;
    logic              in_ack_q, in_ack_d;
    logic              ack_sample_s;
    logic              ack_rise_s;
    logic              wr_ready_s;
    logic              valid_s;
    logic              push_s;
    logic              pop_s;

`ifdef OUTPUT_FIFO_ACK_SYNC_EN
    logic ack_sync1_q, ack_sync1_d;
    logic ack_sync2_q, ack_sync2_d;

    // Two-stage synchronizer for the asynchronous host ack pin
    always_comb begin
        ack_sync1_d  = bus.output_acknowledge;
        ack_sync2_d  = ack_sync1_q;
        ack_sample_s = ack_sync2_q;
    end

    // Synchronizer flops reset high so an ack held through reset is not a new edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync1_q <= 1'b1;
            ack_sync2_q <= 1'b1;
        end else begin
            ack_sync1_q <= ack_sync1_d;
            ack_sync2_q <= ack_sync2_d;
        end
    end
`else
    // Ack pin sampled directly at the clock edge
    always_comb begin
        ack_sample_s = bus.output_acknowledge;
    end
`endif

    // Handshake qualification and head-word presentation
    always_comb begin
        wr_ready_s = (fill_q != CNT_W'(DEPTH));
        valid_s    = (fill_q != CNT_W'(0));
        ack_rise_s = ack_sample_s && !ack_prev_q;
        push_s     = bus.wr_valid && wr_ready_s;
        pop_s      = ack_rise_s && valid_s;
    end

    // Next-state computation: flush overrides push/pop, ack history always advances
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        ack_prev_d = ack_sample_s;
        in_ack_d   = interface_busy;
        if (flush) begin
            wr_ptr_d   = PTR_W'(0);
            rd_ptr_d   = PTR_W'(0);
            fill_d     = CNT_W'(0);
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = bus.wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // Simultaneous push and pop leaves the level unchanged
            case ({push_s, pop_s})
                2'b10:   fill_d = fill_q + CNT_W'(1);
                2'b01:   fill_d = fill_q - CNT_W'(1);
                default: fill_d = fill_q;
            endcase
            if (bus.wr_valid && !wr_ready_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= PTR_W'(0);
            rd_ptr_q   <= PTR_W'(0);
            fill_q     <= CNT_W'(0);
            overflow_q <= 1'b0;
            ack_prev_q <= 1'b1;
            in_ack_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            ack_prev_q <= ack_prev_d;
            in_ack_q   <= in_ack_d;
        end
    end

    // Output drive; the head word reads as zero while the buffer is empty
    always_comb begin
        if (valid_s) begin
            bus.data_out = mem_q[rd_ptr_q];
        end else begin
            bus.data_out = '0;
        end
        bus.output_byte_is_ready = valid_s;
        bus.wr_ready             = wr_ready_s;
        fill_level               = fill_q;
        overflow                 = overflow_q;
        input_acknowledged       = in_ack_q;
    end
endmodule

// File: tb/tb_output_byte_fifo.sv
// Directed self-checking bench for output_byte_fifo (DEPTH=4, DATA_W=8).
module tb_output_byte_fifo;
`ifdef OUTPUT_FIFO_ACK_SYNC_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       interface_busy;
    logic       input_acknowledged;
    logic [2:0] fill_level;
    logic       overflow;
    int         n_tests = 0;
    int         n_fail  = 0;

    output_byte_fifo_if #(.DATA_W(8)) bus ();

    output_byte_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .interface_busy     (interface_busy),
        .input_acknowledged (input_acknowledged),
        .fill_level         (fill_level),
        .overflow           (overflow),
        .bus                (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        step(1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.output_acknowledge = 1'b1;
        step(ACK_LAT);
        bus.output_acknowledge = 1'b0;
        step(ACK_LAT);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.output_acknowledge = 1'b1;
        step(2);
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        n_tests++; if (bus.output_byte_is_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.output_byte_is_ready); end
        n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_tests++; if (input_acknowledged !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack: got %b want 0", input_acknowledged); end
        rst = 1'b0;
        bus.output_acknowledge = 1'b0;
        step(ACK_LAT + 1);
    endtask

    task automatic test_single_push();
        push(8'hA1);
        n_tests++; if (bus.data_out !== 8'hA1) begin n_fail++; $display("FAIL single_data: got %h want a1", bus.data_out); end
        n_tests++; if (bus.output_byte_is_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", bus.output_byte_is_ready); end
        n_tests++; if (fill_level !== 3'd1) begin n_fail++; $display("FAIL single_fill: got %0d want 1", fill_level); end
        ack_pulse();
        n_tests++; if (bus.output_byte_is_ready !== 1'b0) begin n_fail++; $display("FAIL single_pop_ready: got %b want 0", bus.output_byte_is_ready); end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL single_pop_data: got %h want 00", bus.data_out); end
    endtask

    task automatic test_ack_latency();
        push(8'h5A);
        push(8'hA5);
        bus.output_acknowledge = 1'b1;
        if (ACK_LAT > 1) begin
            step(ACK_LAT - 1);
            n_tests++; if (bus.data_out !== 8'h5A) begin n_fail++; $display("FAIL lat_early: got %h want 5a", bus.data_out); end
        end
        step(1);
        n_tests++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL lat_advance: got %h want a5", bus.data_out); end
        bus.output_acknowledge = 1'b0;
        step(ACK_LAT);
        ack_pulse();
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL lat_drain: got %0d want 0", fill_level); end
    endtask

    task automatic test_full_overflow();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        n_tests++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %b want 0", bus.wr_ready); end
        n_tests++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL full_fill: got %0d want 4", fill_level); end
        push(8'h55);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_tests++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL ovf_fill: got %0d want 4", fill_level); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.data_out !== exp_q[i]) begin n_fail++; $display("FAIL ovf_order%0d: got %h want %h", i, bus.data_out, exp_q[i]); end
            ack_pulse();
        end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL ovf_empty_data: got %h want 00", bus.data_out); end
        n_tests++; if (bus.output_byte_is_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_ready: got %b want 0", bus.output_byte_is_ready); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        ack_pulse();
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL underflow_fill: got %0d want 0", fill_level); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_clr_ovf: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
        push(8'hBF);
        ack_pulse();
        n_tests++; if (fill_level !== 3'd3) begin n_fail++; $display("FAIL preflush_fill: got %0d want 3", fill_level); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL preflush_ovf: got %b want 1", overflow); end
        flush = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h99;
        step(1);
        flush = 1'b0;
        bus.wr_valid = 1'b0;
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL flush_fill: got %0d want 0", fill_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", overflow); end
        n_tests++; if (bus.output_byte_is_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.output_byte_is_ready); end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL flush_data: got %h want 00", bus.data_out); end
    endtask

    task automatic test_ack_hold();
        push(8'h77);
        push(8'h88);
        bus.output_acknowledge = 1'b1;
        step(5);
        n_tests++; if (fill_level !== 3'd1) begin n_fail++; $display("FAIL hold_fill: got %0d want 1", fill_level); end
        n_tests++; if (bus.data_out !== 8'h88) begin n_fail++; $display("FAIL hold_data: got %h want 88", bus.data_out); end
        bus.output_acknowledge = 1'b0;
        step(ACK_LAT);
        ack_pulse();
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL hold_drain: got %0d want 0", fill_level); end
    endtask

    task automatic test_push_pop();
        push(8'h01);
        push(8'h02);
        bus.output_acknowledge = 1'b1;
        step(ACK_LAT - 1);
        push(8'h66);
        n_tests++; if (fill_level !== 3'd2) begin n_fail++; $display("FAIL pp_fill: got %0d want 2", fill_level); end
        n_tests++; if (bus.data_out !== 8'h02) begin n_fail++; $display("FAIL pp_head: got %h want 02", bus.data_out); end
        bus.output_acknowledge = 1'b0;
        step(ACK_LAT);
        ack_pulse();
        n_tests++; if (bus.data_out !== 8'h66) begin n_fail++; $display("FAIL pp_tail: got %h want 66", bus.data_out); end
        ack_pulse();
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL pp_drain: got %0d want 0", fill_level); end
    endtask

    task automatic test_input_ack();
        interface_busy = 1'b1;
        n_tests++; if (input_acknowledged !== 1'b0) begin n_fail++; $display("FAIL inack_early: got %b want 0", input_acknowledged); end
        step(1);
        n_tests++; if (input_acknowledged !== 1'b1) begin n_fail++; $display("FAIL inack_high: got %b want 1", input_acknowledged); end
        interface_busy = 1'b0;
        step(1);
        n_tests++; if (input_acknowledged !== 1'b0) begin n_fail++; $display("FAIL inack_low: got %b want 0", input_acknowledged); end
    endtask

    task automatic test_reset_mid();
        push(8'hC1);
        push(8'hC2);
        interface_busy = 1'b1;
        step(1);
        bus.output_acknowledge = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        interface_busy = 1'b0;
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL rmid_fill: got %0d want 0", fill_level); end
        n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", bus.data_out); end
        n_tests++; if (input_acknowledged !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ack: got %b want 0", input_acknowledged); end
        n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_wr_ready: got %b want 1", bus.wr_ready); end
        push(8'hC3);
        step(ACK_LAT + 1);
        n_tests++; if (bus.data_out !== 8'hC3) begin n_fail++; $display("FAIL rmid_held_ack: got %h want c3", bus.data_out); end
        bus.output_acknowledge = 1'b0;
        step(ACK_LAT);
        ack_pulse();
        n_tests++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL rmid_drain: got %0d want 0", fill_level); end
    endtask

    initial begin
        rst                    = 1'b1;
        flush                  = 1'b0;
        interface_busy         = 1'b0;
        bus.wr_valid           = 1'b0;
        bus.wr_data            = 8'h00;
        bus.output_acknowledge = 1'b1;
        step(1);
        test_reset();
        test_single_push();
        test_ack_latency();
        test_full_overflow();
        test_flush();
        test_ack_hold();
        test_push_pop();
        test_input_ack();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
